// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the PWM duty-ramp controller and its phase counter.
package pwm_ctrl_pkg;

  localparam int unsigned DUTY_W = 8;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/pwm_phase_counter.sv
// Free-running PWM phase counter; wrap_o marks the last enabled cycle of a period.
module pwm_phase_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] phase_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] phase_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else if (en_i) begin
      phase_q <= phase_q + 1'b1;
    end
  end

  assign phase_o = phase_q;
  assign wrap_o  = en_i && (phase_q == '1);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer; duty steps land only on PWM period boundaries.
// Optional PWM_RAMP_ABORT_EN adds an abort input that freezes duty and ends the ramp.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned RESOLUTION = DUTY_W,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [RESOLUTION-1:0] cmd_target,
  input  logic [RESOLUTION-1:0] cmd_step,
  input  logic [DIV_WIDTH-1:0]  cmd_div,
  output logic [RESOLUTION-1:0] duty,
  output logic                  period_wrap,
  output logic                  busy,
  output logic                  done
`ifdef PWM_RAMP_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  ramp_state_e           state_q, state_d;
  logic [RESOLUTION-1:0] duty_q, duty_d;
  logic [RESOLUTION-1:0] target_q, target_d;
  logic [RESOLUTION-1:0] step_q, step_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic                  done_q, done_d;

  logic [RESOLUTION-1:0] phase;
  logic [RESOLUTION:0]   sum;
  logic [RESOLUTION:0]   diff;
  logic [RESOLUTION-1:0] step_val;
  logic [DIV_WIDTH-1:0]  div_last;
  logic                  abort_req;

  pwm_phase_counter #(
    .WIDTH (RESOLUTION)
  ) u_phase (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (enable),
    .phase_o (phase),
    .wrap_o  (period_wrap)
  );

`ifdef PWM_RAMP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // One extra bit catches carry/borrow so the clamp to target never wraps.
  always_comb begin
    sum  = {1'b0, duty_q} + {1'b0, step_q};
    diff = {1'b0, duty_q} - {1'b0, step_q};
    if (step_q == '0) begin
      step_val = target_q;
    end else if (target_q > duty_q) begin
      step_val = (sum > {1'b0, target_q}) ? target_q : sum[RESOLUTION-1:0];
    end else begin
      step_val = (diff[RESOLUTION] || (diff[RESOLUTION-1:0] < target_q)) ?
                 target_q : diff[RESOLUTION-1:0];
    end
  end

  assign div_last  = (div_q == '0) ? '0 : div_q - 1'b1;
  assign cmd_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    target_d  = target_q;
    step_d    = step_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          target_d  = cmd_target;
          step_d    = cmd_step;
          div_d     = cmd_div;
          div_cnt_d = '0;
          if (cmd_target == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (period_wrap) begin
          if (div_cnt_q == div_last) begin
            duty_d    = step_val;
            div_cnt_d = '0;
            if (step_val == target_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      target_q  <= '0;
      step_q    <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      step_q    <= step_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end

  assign duty = duty_q;
  assign busy = (state_q == RAMP);
  assign done = done_q;

  a_wrap_at_phase_max: assert property (
    @(posedge clk) disable iff (reset) period_wrap |-> (phase == '1)
  );

endmodule
